// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - state codes, default geometry and output-index encoding for conv_sched
package conv_sched_pkg;

  localparam int IMG_W_DEF = 4;
  localparam int K_DEF     = 3;
  localparam int OUT_W_DEF = IMG_W_DEF - K_DEF + 1;
  localparam int KK_DEF    = K_DEF * K_DEF;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_POOL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Output positions are numbered row-major: row*OUT_W+col.
  function automatic logic [1:0] out_idx_of(input int unsigned r, input int unsigned c,
                                            input int unsigned out_w);
    return 2'(r * out_w + c);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - combinational ifm/weight buffer address generator for conv_sched
module conv_addr_gen #(
  parameter int IMG_W = 4,
  parameter int K     = 3,
  parameter int AW    = 4,
  parameter int RW    = 1,
  parameter int KW    = 2
) (
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] c,
  input  logic [KW-1:0] kr,
  input  logic [KW-1:0] kc,
  output logic [AW-1:0] ifm_addr,
  output logic [AW-1:0] wgt_addr
);

  always_comb begin
    ifm_addr = (AW'(r) + AW'(kr)) * AW'(IMG_W) + AW'(c) + AW'(kc);
    wgt_addr = AW'(kr) * AW'(K) + AW'(kc);
  end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - 3x3 conv sequencer over a 4x4 map driving one shared MAC PE
// Optional 2x2 pool trigger state is built only when CONV_SCHED_POOL_EN is defined.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int K     = K_DEF,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state,
  output logic [AW-1:0] ifm_addr,
  output logic [AW-1:0] wgt_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          out_we,
  output logic [1:0]    out_idx,
  output logic          pool_en
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int RW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d, c_q, c_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;

  logic last_tap, last_pos;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    kr_d     = kr_q;
    kc_d     = kc_q;
    last_tap = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
    last_pos = (r_q == RW'(OUT_W - 1)) && (c_q == RW'(OUT_W - 1));
    case (state_q)
      ST_IDLE: begin
        r_d  = '0;
        c_d  = '0;
        kr_d = '0;
        kc_d = '0;
        if (start) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (!hold) begin
          if (kc_q == KW'(K - 1)) begin
            kc_d = '0;
            kr_d = (kr_q == KW'(K - 1)) ? '0 : kr_q + 1'b1;
          end else begin
            kc_d = kc_q + 1'b1;
          end
          if (last_tap) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!hold) begin
          if (c_q == RW'(OUT_W - 1)) begin
            c_d = '0;
            r_d = (r_q == RW'(OUT_W - 1)) ? '0 : r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
`ifdef CONV_SCHED_POOL_EN
          state_d = last_pos ? ST_POOL : ST_CONV;
`else
          state_d = last_pos ? ST_DONE : ST_CONV;
`endif
        end
      end
`ifdef CONV_SCHED_POOL_EN
      ST_POOL: state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      // Illegal codes recover to IDLE with counters cleared.
      default: begin
        state_d = ST_IDLE;
        r_d     = '0;
        c_d     = '0;
        kr_d    = '0;
        kc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
    end
  end

  conv_addr_gen #(
    .IMG_W(IMG_W),
    .K    (K),
    .AW   (AW),
    .RW   (RW),
    .KW   (KW)
  ) u_addr_gen (
    .r       (r_q),
    .c       (c_q),
    .kr      (kr_q),
    .kc      (kc_q),
    .ifm_addr(ifm_addr),
    .wgt_addr(wgt_addr)
  );

  always_comb begin
    state   = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    mac_en  = (state_q == ST_CONV) && !hold;
    mac_clr = (state_q == ST_CONV) && !hold && (kr_q == '0) && (kc_q == '0);
    out_we  = (state_q == ST_WRITE) && !hold;
    out_idx = out_idx_of(32'(r_q), 32'(c_q), OUT_W);
`ifdef CONV_SCHED_POOL_EN
    pool_en = (state_q == ST_POOL);
`else
    pool_en = 1'b0;
`endif
  end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencer that time-shares one 8-bit MAC processing element across a full 3x3 convolution of a 4x4 input feature map, then optionally triggers the 2x2 pooling stage. Sits between the top-level control and the PE / conv / pool datapath. Issues input and weight buffer addresses, accumulator clear/enable, result write strobes and a visible 3-bit state code for the display path.

## Interface
Parameters:
- IMG_W, 4, input feature-map width and height.
- K, 3, kernel width and height; OUT_W = IMG_W-K+1 (2 at defaults).
- AW, 4, address width for the ifm and weight buffers; must satisfy 2^AW >= IMG_W*IMG_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled only in IDLE.
- hold  in  1  datapath stall; freezes sequencing.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse in DONE.
- state  out  3  current state code.
- ifm_addr  out  AW  input buffer read address.
- wgt_addr  out  AW  weight buffer read address.
- mac_clr  out  1  load the accumulator with the current product instead of adding.
- mac_en  out  1  accumulate the current product.
- out_we  out  1  write the accumulator to output register out_idx.
- out_idx  out  2  output position, row*OUT_W+col (00,01,10,11).
- pool_en  out  1  one-cycle trigger for the 2x2 pool stage.

## Operation
- State codes: IDLE=0, CONV=1, WRITE=2, POOL=3, DONE=4. Codes 5-7 are illegal and go to IDLE on the next edge.
- Counters: output row/col r,c in 0..OUT_W-1; kernel row/col kr,kc in 0..K-1.
- IDLE: all counters are zero. start=1 moves the block to CONV.
- CONV: one tap per cycle. mac_en=1. mac_clr=1 on the tap kr=kc=0.
  - ifm_addr=(r+kr)*IMG_W+(c+kc); wgt_addr=kr*K+kc.
  - kc increments, wrapping into kr. After tap (K-1,K-1) the block goes to WRITE.
- WRITE: out_we=1 for one cycle, out_idx=r*OUT_W+c.
  - c increments, wrapping into r.
  - If this was the last position, go to POOL; otherwise go to CONV with kr=kc=0.
- POOL: pool_en=1 for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored here.
- hold=1 in CONV or WRITE: counters and state freeze, and mac_en, mac_clr and out_we are forced to 0. Addresses stay stable. hold is ignored in IDLE, POOL and DONE.
- start while busy is ignored; no queuing.
- rst at any time: state goes to IDLE and counters clear on that edge. Any in-flight computation is abandoned.

## Timing
- Reset values: state=0; busy, done, mac_clr, mac_en, out_we and pool_en are 0; ifm_addr, wgt_addr and out_idx are 0.
- state and the counters are registered. All outputs decode from them; mac_en, mac_clr and out_we are additionally gated by hold. The only combinational input-to-output path is from hold.
- Buffer reads are combinational, so an address is valid in the same cycle as its mac_en.
- Cycle budget with start seen at edge 0 and hold=0:
  - CONV occupies cycles 1-9; first WRITE at cycle 10.
  - Each output position takes 10 cycles (K*K + 1); the last WRITE is at cycle 40.
  - POOL at cycle 41, DONE at cycle 42, IDLE at cycle 43. start is accepted again from cycle 43.
- Each hold cycle adds exactly one cycle of latency.

## Configuration
- CONV_SCHED_POOL_EN defined: the POOL state exists, and WRITE of the last position goes to POOL.
- Not defined: the POOL state is removed. WRITE of the last position goes straight to DONE, pool_en is tied to 0, DONE falls at cycle 41, and code 3 is illegal.

## Structure
- Package conv_sched_pkg holds:
  - the state code localparams (IDLE..DONE) and the 3-bit state typedef;
  - default IMG_W and K, and the derived OUT_W and K*K;
  - the out_idx encoding.
- One sub-module, conv_addr_gen: purely combinational, computes ifm_addr and wgt_addr from r, c, kr, kc.
- FSM and counters stay in conv_sched.

## Test plan
- Reset, then start pulse at edge 0, hold=0: mac_en is high for 36 cycles total, and out_we fires at cycles 10/20/30/40 with out_idx 0/1/2/3. pool_en at 41, done at 42, state=0 at 43.
- Address check for position out_idx=3 (r=1,c=1): ifm_addr sequence 5,6,7,9,10,11,13,14,15; wgt_addr 0..8; mac_clr only on the first tap.
- hold=1 for 3 cycles during position 1 tap 4: addresses are frozen and mac_en=0 throughout; the final done moves to cycle 45.
- start held high continuously: runs back-to-back, each started from IDLE, with done pulses 43 cycles apart and no overlap.
- rst asserted at cycle 25 in CONV: the next cycle shows state=0, busy=0, all strobes 0 and addresses 0; a new start completes in the normal 42 cycles.
- Build without CONV_SCHED_POOL_EN: pool_en is never asserted, and done comes at cycle 41 instead of 42.
